// File: rtl/line_cmd_scheduler_pkg.sv
// Shared types and helpers for the wireframe line front end.
package gfx_line_pkg;

  localparam int COORD_W = 11;
  localparam int COLOR_W = 32;

  // One line command as carried on a requester's req_cmd slice.
  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x0;
  } line_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_STEP
  } sched_state_e;

  // Byte address of pixel (x,y) for 32-bit pixels and a power-of-two row
  // stride. Shift/add only; the caller truncates to its address width.
  function automatic logic [63:0] pix_addr_f(input logic [63:0] base,
                                             input int          stride_sh,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    return base + ({32'd0, y} << stride_sh) + ({32'd0, x} << 2);
  endfunction

endpackage

// File: rtl/line_cmd_scheduler_if.sv
// Command-side and pixel-write-side handshakes of the line scheduler.
interface line_cmd_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int COORD_W = 11,
  parameter int COLOR_W = 32,
  parameter int ADDR_W  = 32
);
  localparam int CMD_W = 4*COORD_W + COLOR_W;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][CMD_W-1:0] req_cmd;    // requester 0 in the LSBs

  logic                          pix_init;
  logic [ADDR_W-1:0]             pix_addr;
  logic [COLOR_W-1:0]            pix_data;
  logic                          pix_done;
  logic                          pix_error;

  // Scheduler side
  modport master (
    input  req_valid, req_cmd,
    output req_ready,
    output pix_init, pix_addr, pix_data,
    input  pix_done, pix_error
  );

  // Requesters plus pixel write engine side
  modport slave (
    output req_valid, req_cmd,
    input  req_ready,
    input  pix_init, pix_addr, pix_data,
    output pix_done, pix_error
  );
endinterface

// File: rtl/line_cmd_scheduler_arb.sv
// Round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] r_last;
  logic          w_found;
  int            w_cand;

  // First requesting index after r_last, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = 0;
    for (int i = 1; i <= N; i++) begin
      w_cand = (int'(r_last) + i) % N;
      if (!w_found && req[w_cand]) begin
        w_found         = 1'b1;
        grant[w_cand]   = 1'b1;
        grant_idx       = IW'(w_cand);
      end
    end
  end

  // Move the pointer only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_last <= IW'(N-1);
    else if (advance && |req)  r_last <= grant_idx;
  end
endmodule

// File: rtl/line_cmd_scheduler.sv
// Line command scheduler: arbitrates requesters, walks each line with
// Bresenham stepping and issues one pixel write at a time.
module line_cmd_scheduler
  import gfx_line_pkg::*;
#(
  parameter int                NUM_REQ   = 2,
  parameter int                COORD_W   = 11,
  parameter int                COLOR_W   = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] FB_BASE   = 32'h1000_0000,
  parameter int                FB_STRIDE = 4096
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  line_cmd_scheduler_if.master       bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_sticky,
  input  logic                       err_clr,
  output logic [15:0]                line_count
);
  localparam int GW        = $clog2(NUM_REQ);
  localparam int CMD_W     = 4*COORD_W + COLOR_W;
  localparam int SW        = COORD_W + 2;
  localparam int STRIDE_SH = $clog2(FB_STRIDE);

  sched_state_e           r_state;
  logic [COORD_W-1:0]     r_x0, r_y0, r_x1, r_y1, r_cur_x, r_cur_y;
  logic [COLOR_W-1:0]     r_color;
  logic signed [SW-1:0]   r_dx, r_dy, r_err;
  logic                   r_sx_neg, r_sy_neg;
  logic                   r_pix_init;
  logic [ADDR_W-1:0]      r_pix_addr;
  logic [COLOR_W-1:0]     r_pix_data;
  logic [GW-1:0]          r_grant;
  logic                   r_err_sticky;
  logic [15:0]            r_line_count;

  logic [NUM_REQ-1:0]     w_grant;
  logic [GW-1:0]          w_gidx;
  logic [CMD_W-1:0]       w_cmd;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (aclk),
    .rst_n     (aresetn),
    .req       (bus.req_valid),
    .advance   (r_state == S_IDLE),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // Ready goes only to the winner, only in IDLE, never while in reset.
  assign bus.req_ready = (r_state == S_IDLE && aresetn) ? w_grant : '0;
  assign w_cmd         = bus.req_cmd[w_gidx];

  // Line setup terms from the latched endpoints.
  logic signed [SW-1:0] w_ddx, w_ddy, w_adx, w_ady;
  assign w_ddx = $signed({2'b00, r_x1}) - $signed({2'b00, r_x0});
  assign w_ddy = $signed({2'b00, r_y1}) - $signed({2'b00, r_y0});
  assign w_adx = w_ddx[SW-1] ? -w_ddx : w_ddx;
  assign w_ady = w_ddy[SW-1] ? -w_ddy : w_ddy;

  // Bresenham step; both axis decisions use the current err.
  logic signed [SW:0]   w_e2, w_dx_e, w_dy_e;
  logic                 w_stepx, w_stepy, w_at_end;
  logic signed [SW-1:0] w_err_nxt;
  logic [COORD_W-1:0]   w_nx, w_ny, w_ax, w_ay;
  assign w_e2      = $signed({r_err, 1'b0});
  assign w_dx_e    = $signed({r_dx[SW-1], r_dx});
  assign w_dy_e    = $signed({r_dy[SW-1], r_dy});
  assign w_stepx   = (w_e2 >= w_dy_e);
  assign w_stepy   = (w_e2 <= w_dx_e);
  assign w_err_nxt = r_err + (w_stepx ? r_dy : SW'(0)) + (w_stepy ? r_dx : SW'(0));
  assign w_nx      = !w_stepx ? r_cur_x : (r_sx_neg ? r_cur_x - COORD_W'(1) : r_cur_x + COORD_W'(1));
  assign w_ny      = !w_stepy ? r_cur_y : (r_sy_neg ? r_cur_y - COORD_W'(1) : r_cur_y + COORD_W'(1));
  assign w_at_end  = (r_cur_x == r_x1) && (r_cur_y == r_y1);

  // Address of the pixel about to be issued: start point from LOAD,
  // stepped point from STEP.
  logic [ADDR_W-1:0] w_addr;
  assign w_ax   = (r_state == S_LOAD) ? r_x0 : w_nx;
  assign w_ay   = (r_state == S_LOAD) ? r_y0 : w_ny;
  assign w_addr = ADDR_W'(pix_addr_f(64'(FB_BASE), STRIDE_SH, 32'(w_ax), 32'(w_ay)));

  logic w_err_evt;
  assign w_err_evt = (r_state == S_WAIT) && bus.pix_done && bus.pix_error;

  // Main sequencer: accept, set up, then issue/wait/step per pixel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_color      <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_err        <= '0;
      r_sx_neg     <= 1'b0;
      r_sy_neg     <= 1'b0;
      r_pix_init   <= 1'b0;
      r_pix_addr   <= '0;
      r_pix_data   <= '0;
      r_grant      <= '0;
      r_err_sticky <= 1'b0;
      r_line_count <= '0;
    end else begin
      r_pix_init <= 1'b0;
      case (r_state)
        S_IDLE: if (|bus.req_valid) begin
          r_x0    <= w_cmd[COORD_W-1:0];
          r_y0    <= w_cmd[2*COORD_W-1:COORD_W];
          r_x1    <= w_cmd[3*COORD_W-1:2*COORD_W];
          r_y1    <= w_cmd[4*COORD_W-1:3*COORD_W];
          r_color <= w_cmd[CMD_W-1:4*COORD_W];
          r_grant <= w_gidx;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_dx       <= w_adx;
          r_dy       <= -w_ady;
          r_err      <= w_adx - w_ady;
          r_sx_neg   <= w_ddx[SW-1];
          r_sy_neg   <= w_ddy[SW-1];
          r_cur_x    <= r_x0;
          r_cur_y    <= r_y0;
          r_pix_addr <= w_addr;
          r_pix_data <= r_color;
          r_pix_init <= 1'b1;
          r_state    <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (bus.pix_done) begin
          r_state <= bus.pix_error ? S_IDLE : S_STEP;
        end
        S_STEP: begin
          if (w_at_end) begin
            r_line_count <= r_line_count + 16'd1;
            r_state      <= S_IDLE;
          end else begin
            r_cur_x    <= w_nx;
            r_cur_y    <= w_ny;
            r_err      <= w_err_nxt;
            r_pix_addr <= w_addr;
            r_pix_init <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A write error in the same cycle as a clear keeps the flag set.
      if (w_err_evt)    r_err_sticky <= 1'b1;
      else if (err_clr) r_err_sticky <= 1'b0;
    end
  end

  assign bus.pix_init = r_pix_init;
  assign bus.pix_addr = r_pix_addr;
  assign bus.pix_data = r_pix_data;
  assign busy         = (r_state != S_IDLE);
  assign grant_id     = r_grant;
  assign err_sticky   = r_err_sticky;
  assign line_count   = r_line_count;
endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Bench for line_cmd_scheduler: vector table, corner sequences and random
// lines checked against an integer Bresenham model.
module tb_line_cmd_scheduler;
  import gfx_line_pkg::*;

  localparam int NR = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        err_clr;
  logic        busy;
  logic [0:0]  grant_id;
  logic        err_sticky;
  logic [15:0] line_count;

  line_cmd_scheduler_if #(.NUM_REQ(NR), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .ADDR_W(32)) bus();

  line_cmd_scheduler #(
    .NUM_REQ(NR), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .ADDR_W(32),
    .FB_BASE(32'h1000_0000), .FB_STRIDE(4096)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus), .busy(busy), .grant_id(grant_id),
    .err_sticky(err_sticky), .err_clr(err_clr), .line_count(line_count)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, viol = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- pixel write engine model ----------------
  logic [31:0] cap_addr[$], cap_data[$];
  int          cap_gid[$], cap_cyc[$];
  int lat = 1, err_at = -1, n_init = 0, last_done_cyc = 0, err_done_cyc = 0;
  bit spur_req = 0, spur_err = 0, clr_req = 0, clr_on_err = 0;
  bit s_pend = 0, s_prev = 0;
  int s_cnt = 0, s_pidx = 0;

  initial begin
    bus.pix_done = 1'b0; bus.pix_error = 1'b0; err_clr = 1'b0;
    forever begin
      @(negedge aclk);
      bus.pix_done = 1'b0; bus.pix_error = 1'b0;
      err_clr = clr_req; clr_req = 0;
      if (!aresetn) begin
        if (bus.pix_init) begin viol++; $display("FAIL pix_init during reset"); end
        s_pend = 0; s_prev = 0;
        continue;
      end
      if (spur_req) begin
        bus.pix_done = 1'b1; bus.pix_error = spur_err; spur_req = 0;
      end else if (s_pend) begin
        if (s_cnt == 0) begin
          bus.pix_done = 1'b1; bus.pix_error = (s_pidx == err_at);
          last_done_cyc = cyc;
          if (bus.pix_error) begin err_done_cyc = cyc; if (clr_on_err) err_clr = 1'b1; end
          s_pend = 0;
        end else s_cnt--;
      end
      if (bus.pix_init) begin
        if (s_prev || s_pend) begin viol++; $display("FAIL pix_init reissued at cycle %0d", cyc); end
        cap_addr.push_back(bus.pix_addr); cap_data.push_back(bus.pix_data);
        cap_gid.push_back(int'(grant_id)); cap_cyc.push_back(cyc);
        s_pend = 1; s_cnt = lat - 1; s_pidx = n_init; n_init++;
      end
      s_prev = bus.pix_init;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  task automatic model_line(input int x0, input int y0, input int x1, input int y1);
    int x, y, dx, dy, sx, sy, e, e2;
    x = x0; y = y0;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    e  = dx + dy;
    exp_q.delete();
    forever begin
      exp_q.push_back(32'h1000_0000 + y*4096 + x*4);
      if (x == x1 && y == y1) break;
      e2 = 2*e;
      if (e2 >= dy) begin e += dy; x += sx; end
      if (e2 <= dx) begin e += dx; y += sy; end
    end
  endtask

  int lc_exp = 0, tb_last = NR-1;

  // Submit one command on requester r and wait for the line to finish.
  task automatic run_line(input int r, input int x0, input int y0, input int x1, input int y1,
                          input logic [31:0] col, output int base, output int t_idle);
    line_cmd_t c;
    int k, t_acc;
    c.x0 = COORD_W'(x0); c.y0 = COORD_W'(y0); c.x1 = COORD_W'(x1); c.y1 = COORD_W'(y1);
    c.color = col;
    base = cap_addr.size();
    t_idle = 0;
    @(negedge aclk);
    bus.req_cmd[r] = c; bus.req_valid[r] = 1'b1;
    #1;
    k = 0;
    while (bus.req_ready[r] !== 1'b1 && k < 100) begin @(negedge aclk); k++; end
    if (k == 100) begin
      chk("accept timeout", 0, 1); bus.req_valid[r] = 1'b0; return;
    end
    chk("req_ready onehot", 64'(bus.req_ready), 64'(1 << r));
    t_acc = cyc; tb_last = r;
    @(negedge aclk);
    bus.req_valid[r] = 1'b0;
    k = 0;
    while (busy && k < 4000) begin @(negedge aclk); k++; end
    if (k == 4000) chk("line timeout", 0, 1);
    t_idle = cyc;
    if (cap_addr.size() > base) chk("first pix_init latency", cap_cyc[base] - t_acc, 2);
    else chk("no pix_init issued", cap_addr.size(), base + 1);
  endtask

  typedef struct {
    int          req, x0, y0, x1, y1;
    logic [31:0] col;
    int          lat, npix;
    logic [31:0] last;
  } vec_t;
  vec_t vt[6];

  // Compare a finished line against the model.
  task automatic check_line(input string nm, input int base, input int r,
                            input int x0, input int y0, input int x1, input int y1, input logic [31:0] col);
    int n; bit eq, deq, geq;
    n = cap_addr.size() - base;
    model_line(x0, y0, x1, y1);
    eq = (n == exp_q.size()); deq = 1; geq = 1;
    for (int j = 0; j < n; j++) begin
      if (eq && cap_addr[base+j] !== exp_q[j]) eq = 0;
      if (cap_data[base+j] !== col) deq = 0;
      if (cap_gid[base+j] != r) geq = 0;
    end
    chk({nm, " addr list"}, 64'(eq), 1);
    chk({nm, " pix_data"}, 64'(deq), 1);
    chk({nm, " grant_id"}, 64'(geq), 1);
  endtask

  initial begin
    int base, t_idle, n0, k, g, gexp;
    logic [NR-1:0] prev_rdy;
    line_cmd_t c;

    vt[0] = '{0, 0, 0, 3, 0, 32'hFF00FF00, 1, 4, 32'h1000_000C};
    vt[1] = '{1, 2, 5, 0, 0, 32'h0000_1234, 2, 6, 32'h1000_0000};
    vt[2] = '{0, 7, 9, 7, 9, 32'hDEAD_BEEF, 3, 1, 32'h1000_901C};
    vt[3] = '{1, 0, 0, 3, 3, 32'h0A0B_0C0D, 1, 4, 32'h1000_300C};
    vt[4] = '{0, 10, 2, 4, 2, 32'h5555_AAAA, 4, 7, 32'h1000_2010};
    vt[5] = '{1, 0, 6, 3, 0, 32'h0000_00FF, 2, 7, 32'h1000_000C};

    bus.req_valid = '0; bus.req_cmd = '0;
    aresetn = 1'b0;
    bus.req_valid[0] = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    chk("reset req_ready", 64'(bus.req_ready), 0);
    chk("reset busy", 64'(busy), 0);
    chk("reset pix_init", 64'(bus.pix_init), 0);
    chk("reset pix_addr", 64'(bus.pix_addr), 0);
    chk("reset line_count", 64'(line_count), 0);
    chk("reset err_sticky", 64'(err_sticky), 0);
    bus.req_valid = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      lat = vt[i].lat;
      run_line(vt[i].req, vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].col, base, t_idle);
      chk($sformatf("v%0d npix", i), cap_addr.size() - base, vt[i].npix);
      if (cap_addr.size() > base)
        chk($sformatf("v%0d last addr", i), cap_addr[cap_addr.size()-1], vt[i].last);
      check_line($sformatf("v%0d", i), base, vt[i].req, vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1, vt[i].col);
      chk($sformatf("v%0d idle timing", i), t_idle, last_done_cyc + 2);
      lc_exp++;
      chk($sformatf("v%0d line_count", i), 64'(line_count), 64'(lc_exp));
    end

    // Error on 2nd pixel aborts the line
    lat = 1; err_at = n_init + 1;
    run_line(0, 0, 0, 5, 0, 32'h1111_2222, base, t_idle);
    repeat (4) @(negedge aclk);
    chk("err abort npix", cap_addr.size() - base, 2);
    chk("err idle timing", t_idle, err_done_cyc + 1);
    chk("err err_sticky", 64'(err_sticky), 1);
    chk("err line_count", 64'(line_count), 64'(lc_exp));
    err_at = -1;
    clr_req = 1;
    repeat (2) @(negedge aclk);
    chk("err_clr clears", 64'(err_sticky), 0);

    // Spurious done (with error) while idle
    spur_err = 1; spur_req = 1;
    repeat (3) @(negedge aclk);
    chk("spurious busy", 64'(busy), 0);
    chk("spurious err_sticky", 64'(err_sticky), 0);
    chk("spurious line_count", 64'(line_count), 64'(lc_exp));

    // err_clr in the same cycle as an error: set wins
    clr_on_err = 1; err_at = n_init;
    run_line(1, 3, 3, 6, 6, 32'h3333_4444, base, t_idle);
    clr_on_err = 0; err_at = -1;
    @(negedge aclk);
    chk("set beats clear", 64'(err_sticky), 1);

    // Sticky error does not block new commands
    run_line(0, 1, 1, 2, 1, 32'h7777_8888, base, t_idle);
    lc_exp++;
    chk("sticky no block line_count", 64'(line_count), 64'(lc_exp));

    // Reset during WAIT of a 10-pixel line
    lat = 5; n0 = n_init;
    c = '0; c.x1 = COORD_W'(9); c.color = 32'h9999_0000;
    @(negedge aclk);
    bus.req_cmd[1] = c; bus.req_valid[1] = 1'b1;
    k = 0;
    while (n_init < n0 + 3 && k < 500) begin @(negedge aclk); k++; end
    bus.req_valid[1] = 1'b0;
    if (k == 500) chk("reset test timeout", 0, 1);
    @(negedge aclk);
    aresetn = 1'b0;
    bus.req_valid[0] = 1'b1;
    #1;
    chk("midline rst busy", 64'(busy), 0);
    chk("midline rst pix_addr", 64'(bus.pix_addr), 0);
    chk("midline rst pix_data", 64'(bus.pix_data), 0);
    chk("midline rst grant_id", 64'(grant_id), 0);
    chk("midline rst err_sticky", 64'(err_sticky), 0);
    chk("midline rst line_count", 64'(line_count), 0);
    chk("midline rst req_ready", 64'(bus.req_ready), 0);
    repeat (3) @(negedge aclk);
    bus.req_valid = '0;
    lc_exp = 0; tb_last = NR-1;
    @(negedge aclk);
    aresetn = 1'b1;
    lat = 2;
    run_line(0, 4, 4, 6, 5, 32'hABCD_0001, base, t_idle);
    check_line("after reset", base, 0, 4, 4, 6, 5, 32'hABCD_0001);
    lc_exp++;
    chk("after reset line_count", 64'(line_count), 64'(lc_exp));

    // Both requesters valid continuously: alternating one-cycle readies
    lat = 1;
    c = '0; c.x0 = COORD_W'(1); c.x1 = COORD_W'(1); c.color = 32'h0000_0001;
    @(negedge aclk);
    bus.req_cmd[0] = c; bus.req_cmd[1] = c;
    bus.req_valid = '1;
    #1;
    g = 0; k = 0; prev_rdy = '0;
    while (g < 4 && k < 200) begin
      if (bus.req_ready != '0) begin
        gexp = (tb_last + 1) % NR;
        chk($sformatf("rr onehot %0d", g), 64'($onehot(bus.req_ready)), 1);
        chk($sformatf("rr pulse %0d", g), 64'(prev_rdy), 0);
        chk($sformatf("rr order %0d", g), 64'(bus.req_ready), 64'(1 << gexp));
        tb_last = gexp; g++;
      end
      if (g < 4) begin
        prev_rdy = bus.req_ready;
        @(negedge aclk); #1; k++;
      end
    end
    if (k == 200) chk("rr timeout", 0, 1);
    @(negedge aclk);
    bus.req_valid = '0;
    k = 0;
    while (busy && k < 200) begin @(negedge aclk); k++; end
    lc_exp += 4;
    chk("rr line_count", 64'(line_count), 64'(lc_exp));

    // Random lines against the model
    for (int i = 0; i < 20; i++) begin
      int r, x0, y0, x1, y1;
      logic [31:0] col;
      r = $urandom_range(NR-1, 0);
      x0 = $urandom_range(15, 0); y0 = $urandom_range(15, 0);
      x1 = $urandom_range(15, 0); y1 = $urandom_range(15, 0);
      col = $urandom;
      lat = $urandom_range(4, 1);
      run_line(r, x0, y0, x1, y1, col, base, t_idle);
      check_line($sformatf("rnd%0d", i), base, r, x0, y0, x1, y1, col);
      lc_exp++;
      chk($sformatf("rnd%0d line_count", i), 64'(line_count), 64'(lc_exp));
    end

    repeat (3) @(negedge aclk);
    chk("pix_init protocol violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
endmodule
